// File: rtl/axi_pkg.sv
// Shared AXI read-path constants and the read arbiter state encoding.
package axi_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'b00,
        ARB_ADDR = 2'b01,
        ARB_DATA = 2'b10
    } arb_state_e;

    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

endpackage

// File: rtl/axi_rd_arbiter_rr_arb2.sv
// Two-way round-robin picker; the previous-grant pointer lives in the parent.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt_idx,
    output logic       any
);

    // On a tie the requester that did not win last time is chosen.
    assign gnt_idx = (req == 2'b11) ? ~last : req[1];
    assign any     = |req;

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI AR/R channel pair between I-cache (0) and D-cache (1) refill engines,
// one burst outstanding, with beat-count and ID checking on the returned data.
//
//  state    | meaning
//  ARB_IDLE | no burst; arbitrate among valid requesters
//  ARB_ADDR | m_ar* presented downstream, waiting for m_arready
//  ARB_DATA | R beats steered to the granted requester until m_rlast
module axi_rd_arbiter
    import axi_pkg::*;
#(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [ID_W-1:0]   s0_arid,
    input  logic [ADDR_W-1:0] s0_araddr,
    input  logic [LEN_W-1:0]  s0_arlen,
    input  logic              s0_arvalid,
    output logic              s0_arready,
    output logic [DATA_W-1:0] s0_rdata,
    output logic [1:0]        s0_rresp,
    output logic              s0_rlast,
    output logic              s0_rvalid,
    input  logic              s0_rready,

    input  logic [ID_W-1:0]   s1_arid,
    input  logic [ADDR_W-1:0] s1_araddr,
    input  logic [LEN_W-1:0]  s1_arlen,
    input  logic              s1_arvalid,
    output logic              s1_arready,
    output logic [DATA_W-1:0] s1_rdata,
    output logic [1:0]        s1_rresp,
    output logic              s1_rlast,
    output logic              s1_rvalid,
    input  logic              s1_rready,

    output logic [ID_W-1:0]   m_arid,
    output logic [ADDR_W-1:0] m_araddr,
    output logic [LEN_W-1:0]  m_arlen,
    output logic              m_arvalid,
    input  logic              m_arready,
    input  logic [ID_W-1:0]   m_rid,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic [1:0]        m_rresp,
    input  logic              m_rlast,
    input  logic              m_rvalid,
    output logic              m_rready,

    output logic              busy,
    output logic              prot_err
);

    arb_state_e        state_q;
    logic              grant_q;
    logic              last_grant_q;
    logic [LEN_W-1:0]  cnt_q;
    logic [ID_W-1:0]   m_arid_q;
    logic [ADDR_W-1:0] m_araddr_q;
    logic [LEN_W-1:0]  m_arlen_q;
    logic              m_arvalid_q;
    logic              s0_arready_q;
    logic              s1_arready_q;
    logic              prot_err_q;

    logic              arb_gnt;
    logic              arb_any;
    logic [ID_W-1:0]   sel_arid_d;
    logic [ADDR_W-1:0] sel_araddr_d;
    logic [LEN_W-1:0]  sel_arlen_d;
    logic              in_data;
    logic              to_s0;
    logic              to_s1;
    logic              beat;
    logic              beat_bad;

    rr_arb2 u_rr_arb2 (
        .req     ({s1_arvalid, s0_arvalid}),
        .last    (last_grant_q),
        .gnt_idx (arb_gnt),
        .any     (arb_any)
    );

    assign sel_arid_d   = arb_gnt ? s1_arid   : s0_arid;
    assign sel_araddr_d = arb_gnt ? s1_araddr : s0_araddr;
    assign sel_arlen_d  = arb_gnt ? s1_arlen  : s0_arlen;

    // R path is gated by state so nothing leaks to either requester outside a burst.
    assign in_data  = (state_q == ARB_DATA);
    assign to_s0    = in_data && !grant_q;
    assign to_s1    = in_data &&  grant_q;
    assign m_rready = (to_s0 && s0_rready) || (to_s1 && s1_rready);
    assign beat     = m_rvalid && m_rready;

    assign s0_rvalid = to_s0 && m_rvalid;
    assign s0_rdata  = to_s0 ? m_rdata : '0;
    assign s0_rresp  = to_s0 ? m_rresp : 2'b00;
    assign s0_rlast  = to_s0 && m_rlast;
    assign s1_rvalid = to_s1 && m_rvalid;
    assign s1_rdata  = to_s1 ? m_rdata : '0;
    assign s1_rresp  = to_s1 ? m_rresp : 2'b00;
    assign s1_rlast  = to_s1 && m_rlast;

    assign beat_bad = (m_rid != m_arid_q)
                   || ( m_rlast && (cnt_q != m_arlen_q))
                   || (!m_rlast && (cnt_q == m_arlen_q));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ARB_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            m_arid_q     <= '0;
            m_araddr_q   <= '0;
            m_arlen_q    <= '0;
            m_arvalid_q  <= 1'b0;
            s0_arready_q <= 1'b0;
            s1_arready_q <= 1'b0;
            prot_err_q   <= 1'b0;
        end else begin
            s0_arready_q <= 1'b0;
            s1_arready_q <= 1'b0;
            case (state_q)
                ARB_IDLE: begin
                    if (m_rvalid) prot_err_q <= 1'b1;
                    if (arb_any) begin
                        grant_q      <= arb_gnt;
                        last_grant_q <= arb_gnt;
                        cnt_q        <= '0;
                        m_arid_q     <= sel_arid_d;
                        m_araddr_q   <= sel_araddr_d;
                        m_arlen_q    <= sel_arlen_d;
                        m_arvalid_q  <= 1'b1;
                        state_q      <= ARB_ADDR;
                    end
                end
                ARB_ADDR: begin
                    if (m_rvalid) prot_err_q <= 1'b1;
                    if (m_arvalid_q && m_arready) begin
                        m_arvalid_q <= 1'b0;
                        if (grant_q) s1_arready_q <= 1'b1;
                        else         s0_arready_q <= 1'b1;
                        state_q <= ARB_DATA;
                    end
                end
                ARB_DATA: begin
                    // A malformed burst still ends only on m_rlast; cnt wraps naturally.
                    if (beat) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (beat_bad) prot_err_q <= 1'b1;
                        if (m_rlast)  state_q    <= ARB_IDLE;
                    end
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

    assign m_arid     = m_arid_q;
    assign m_araddr   = m_araddr_q;
    assign m_arlen    = m_arlen_q;
    assign m_arvalid  = m_arvalid_q;
    assign s0_arready = s0_arready_q;
    assign s1_arready = s1_arready_q;
    assign busy       = (state_q != ARB_IDLE);
    assign prot_err   = prot_err_q;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Randomized bench for axi_rd_arbiter against a round-robin / burst-rule reference model.
module tb_axi_rd_arbiter;

    localparam int ID_W   = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int LEN_W  = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [ID_W-1:0]   s0_arid, s1_arid;
    logic [ADDR_W-1:0] s0_araddr, s1_araddr;
    logic [LEN_W-1:0]  s0_arlen, s1_arlen;
    logic              s0_arvalid, s1_arvalid;
    logic              s0_arready, s1_arready;
    logic [DATA_W-1:0] s0_rdata, s1_rdata;
    logic [1:0]        s0_rresp, s1_rresp;
    logic              s0_rlast, s1_rlast;
    logic              s0_rvalid, s1_rvalid;
    logic              s0_rready, s1_rready;
    logic [ID_W-1:0]   m_arid;
    logic [ADDR_W-1:0] m_araddr;
    logic [LEN_W-1:0]  m_arlen;
    logic              m_arvalid, m_arready;
    logic [ID_W-1:0]   m_rid;
    logic [DATA_W-1:0] m_rdata;
    logic [1:0]        m_rresp;
    logic              m_rlast, m_rvalid, m_rready;
    logic              busy, prot_err;

    int   n_checks = 0;
    int   n_errors = 0;
    int   last_g;
    logic exp_err;

    axi_rd_arbiter #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst),
        .s0_arid(s0_arid), .s0_araddr(s0_araddr), .s0_arlen(s0_arlen), .s0_arvalid(s0_arvalid),
        .s0_arready(s0_arready), .s0_rdata(s0_rdata), .s0_rresp(s0_rresp), .s0_rlast(s0_rlast),
        .s0_rvalid(s0_rvalid), .s0_rready(s0_rready),
        .s1_arid(s1_arid), .s1_araddr(s1_araddr), .s1_arlen(s1_arlen), .s1_arvalid(s1_arvalid),
        .s1_arready(s1_arready), .s1_rdata(s1_rdata), .s1_rresp(s1_rresp), .s1_rlast(s1_rlast),
        .s1_rvalid(s1_rvalid), .s1_rready(s1_rready),
        .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arvalid(m_arvalid),
        .m_arready(m_arready), .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp),
        .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .busy(busy), .prot_err(prot_err)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        s0_arvalid = 1'b0; s1_arvalid = 1'b0;
        s0_rready  = 1'b0; s1_rready  = 1'b0;
        m_arready  = 1'b0; m_rvalid   = 1'b0; m_rlast = 1'b0;
        m_rid = '0; m_rdata = '0; m_rresp = 2'b00;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        last_g  = 1;
        exp_err = 1'b0;
    endtask

    task automatic new_req(input int n, input logic [ADDR_W-1:0] a, input int len, input int id);
        if (n == 0) begin
            s0_araddr = a; s0_arlen = LEN_W'(len); s0_arid = ID_W'(id); s0_arvalid = 1'b1;
        end else begin
            s1_araddr = a; s1_arlen = LEN_W'(len); s1_arid = ID_W'(id); s1_arvalid = 1'b1;
        end
    endtask

    // Called at negedge+1 with the arbiter idle; serves one burst end to end.
    task automatic run_burst(input int ar_dly, input int rlast_at, input logic [ID_W-1:0] rid_xor,
                             input bit bp_toggle, input int abort_at);
        int g, w, b, guard;
        bit done, rr;
        logic [ID_W-1:0]   e_id;
        logic [ADDR_W-1:0] e_addr;
        logic [LEN_W-1:0]  e_len;
        logic              win_rvalid, lose_rvalid, win_rlast;
        logic [DATA_W-1:0] win_rdata;
        logic [1:0]        win_rresp;

        if (s0_arvalid && s1_arvalid) g = 1 - last_g;
        else                          g = s1_arvalid ? 1 : 0;
        e_id   = g ? s1_arid   : s0_arid;
        e_addr = g ? s1_araddr : s0_araddr;
        e_len  = g ? s1_arlen  : s0_arlen;

        w = 0;
        do begin
            @(negedge clk); #1;
            w++;
        end while (!m_arvalid && w < 8);
        check_eq("ar_latency", 64'(w), 64'd1);
        check_eq("m_ar_fields", {m_arvalid, m_arid, m_arlen, m_araddr}, {1'b1, e_id, e_len, e_addr});
        check_eq("busy_addr", busy, 1'b1);
        last_g = g;

        for (int i = 0; i < ar_dly; i++) begin
            @(negedge clk); #1;
            check_eq("ar_hold", {m_arvalid, m_araddr}, {1'b1, e_addr});
            check_eq("early_arready", s0_arready | s1_arready, 1'b0);
        end
        @(negedge clk);
        m_arready = 1'b1;
        @(negedge clk);
        m_arready = 1'b0;
        #1;
        check_eq("arready_win", g ? s1_arready : s0_arready, 1'b1);
        check_eq("arready_lose", g ? s0_arready : s1_arready, 1'b0);
        check_eq("m_arvalid_clr", m_arvalid, 1'b0);
        if (g == 1) s1_arvalid = 1'b0;
        else        s0_arvalid = 1'b0;

        b = 0; done = 1'b0; guard = 0;
        while (!done && guard < 400) begin
            @(negedge clk);
            m_rvalid = bp_toggle ? 1'b1 : ($urandom_range(0, 3) != 0);
            m_rdata  = $urandom;
            m_rresp  = 2'($urandom_range(0, 3));
            m_rid    = e_id ^ rid_xor;
            m_rlast  = (b == rlast_at);
            rr       = bp_toggle ? (guard % 2 == 0) : ($urandom_range(0, 2) != 0);
            s0_rready = (g == 0) ? rr : 1'($urandom_range(0, 1));
            s1_rready = (g == 1) ? rr : 1'($urandom_range(0, 1));
            #1;
            win_rvalid  = g ? s1_rvalid : s0_rvalid;
            lose_rvalid = g ? s0_rvalid : s1_rvalid;
            win_rdata   = g ? s1_rdata  : s0_rdata;
            win_rresp   = g ? s1_rresp  : s0_rresp;
            win_rlast   = g ? s1_rlast  : s0_rlast;
            if (guard == 0) check_eq("arready_one_cycle", s0_arready | s1_arready, 1'b0);
            check_eq("m_rready", m_rready, rr);
            check_eq("rvalid_win", win_rvalid, m_rvalid);
            check_eq("rvalid_lose", lose_rvalid, 1'b0);
            if (m_rvalid && rr) begin
                check_eq("rdata", win_rdata, m_rdata);
                check_eq("rlast_rresp", {win_rlast, win_rresp}, {m_rlast, m_rresp});
                if ((m_rid != e_id) ||
                    ( m_rlast && ((b % (1 << LEN_W)) != int'(e_len))) ||
                    (!m_rlast && ((b % (1 << LEN_W)) == int'(e_len))))
                    exp_err = 1'b1;
                b++;
                if (m_rlast) done = 1'b1;
                if (abort_at >= 0 && b == abort_at) begin
                    @(negedge clk);
                    m_rvalid = 1'b1; s0_rready = 1'b1; s1_rready = 1'b1;
                    rst = 1'b0;
                    #1;
                    check_eq("rst_busy_err", {busy, prot_err}, 2'b00);
                    check_eq("rst_rvalid", {s0_rvalid, s1_rvalid, m_rready}, 3'b000);
                    check_eq("rst_ar", {m_arvalid, m_arid, m_arlen, m_araddr}, '0);
                    check_eq("rst_arready", {s0_arready, s1_arready}, 2'b00);
                    clear_inputs();
                    @(negedge clk);
                    rst = 1'b1;
                    last_g  = 1;
                    exp_err = 1'b0;
                    return;
                end
            end
            guard++;
        end
        check_eq("burst_done", done, 1'b1);
        check_eq("beat_count", 64'(b), 64'(rlast_at + 1));
        @(negedge clk);
        m_rvalid = 1'b0; m_rlast = 1'b0;
        #1;
        check_eq("idle_after_burst", busy, 1'b0);
        check_eq("prot_err", prot_err, exp_err);
    endtask

    initial begin
        int len;
        clear_inputs();
        s0_arid = '0; s0_araddr = '0; s0_arlen = '0;
        s1_arid = '0; s1_araddr = '0; s1_arlen = '0;
        last_g = 1; exp_err = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        check_eq("reset_state", {busy, prot_err, m_arvalid, s0_arready, s1_arready, m_rready}, '0);
        check_eq("reset_ar", {m_arid, m_arlen, m_araddr}, '0);
        @(negedge clk);
        rst = 1'b1;

        // Single requester, long burst
        @(negedge clk); #1;
        new_req(0, 32'h1FC0_0040, 15, 1);
        run_burst(1, 15, '0, 1'b0, -1);

        // Simultaneous requests from reset alternate strictly
        apply_reset();
        @(negedge clk); #1;
        new_req(0, 32'h0000_1000, 3, 2);
        new_req(1, 32'h8000_2000, 1, 5);
        run_burst(0, 3, '0, 1'b0, -1);
        run_burst(2, 1, '0, 1'b0, -1);
        new_req(0, 32'h0000_1100, 2, 3);
        new_req(1, 32'h8000_2100, 0, 6);
        run_burst(1, 2, '0, 1'b0, -1);
        run_burst(0, 0, '0, 1'b0, -1);

        // R backpressure on requester 1
        new_req(1, 32'h8000_3000, 3, 7);
        run_burst(0, 3, '0, 1'b1, -1);

        // Random traffic
        for (int k = 0; k < 40; k++) begin
            for (int n = 0; n < 2; n++) begin
                if (!(n == 0 ? s0_arvalid : s1_arvalid) && $urandom_range(0, 1) == 1) begin
                    len = ($urandom_range(0, 7) == 0) ? 15 : int'($urandom_range(0, 6));
                    new_req(n, $urandom, len, int'($urandom_range(0, 15)));
                end
            end
            if (!s0_arvalid && !s1_arvalid) begin
                len = int'($urandom_range(0, 6));
                new_req(int'($urandom_range(0, 1)), $urandom, len, int'($urandom_range(0, 15)));
            end
            len = (s0_arvalid && s1_arvalid) ? int'((last_g == 1) ? s0_arlen : s1_arlen)
                                             : int'(s1_arvalid ? s1_arlen : s0_arlen);
            run_burst(int'($urandom_range(0, 3)), len, '0, 1'b0, -1);
        end

        // Early rlast
        apply_reset();
        @(negedge clk); #1;
        new_req(0, 32'h0000_4000, 3, 1);
        run_burst(0, 2, '0, 1'b0, -1);

        // RID mismatch (rid=2 against arid=1)
        apply_reset();
        @(negedge clk); #1;
        new_req(0, 32'h0000_5000, 3, 1);
        run_burst(0, 3, 4'h3, 1'b0, -1);

        // Reset mid-DATA, then a fresh request from requester 1
        apply_reset();
        @(negedge clk); #1;
        new_req(0, 32'h1FC0_0080, 15, 1);
        run_burst(1, 15, '0, 1'b0, 5);
        @(negedge clk); #1;
        new_req(1, 32'h8000_6000, 2, 9);
        run_burst(0, 2, '0, 1'b0, -1);

        // Stray R beat while idle
        @(negedge clk);
        m_rvalid = 1'b1; s0_rready = 1'b1; s1_rready = 1'b1;
        #1;
        check_eq("stray_gating", {m_rready, s0_rvalid, s1_rvalid}, 3'b000);
        @(negedge clk);
        m_rvalid = 1'b0;
        #1;
        check_eq("stray_prot_err", prot_err, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
